// File: rtl/pong_pkg.sv
// Shared encodings for the pong match controller: FSM states, regime and winner codes.
package pong_pkg;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_SERVE_WAIT = 3'd1;
    localparam logic [2:0] ST_PLAY       = 3'd2;
    localparam logic [2:0] ST_PAUSE      = 3'd3;
    localparam logic [2:0] ST_POINT_HOLD = 3'd4;
    localparam logic [2:0] ST_GAME_OVER  = 3'd5;

    localparam logic [1:0] REGIME_IDLE   = 2'b00;
    localparam logic [1:0] REGIME_MATCH  = 2'b01;
    localparam logic [1:0] REGIME_PAUSED = 2'b10;
    localparam logic [1:0] REGIME_OVER   = 2'b11;

    localparam logic [1:0] WIN_NONE  = 2'b00;
    localparam logic [1:0] WIN_LEFT  = 2'b01;
    localparam logic [1:0] WIN_RIGHT = 2'b10;

    function automatic logic [1:0] regime_of(input logic [2:0] st);
        case (st)
            ST_IDLE:      regime_of = REGIME_IDLE;
            ST_PAUSE:     regime_of = REGIME_PAUSED;
            ST_GAME_OVER: regime_of = REGIME_OVER;
            default:      regime_of = REGIME_MATCH;
        endcase
    endfunction

endpackage

// File: rtl/pong_frame_timer.sv
// Frame-tick detection at the first blanking line, end-of-frame accelerometer
// capture and the per-state frame counter.
module pong_frame_timer #(
    parameter int V_ACTIVE = 600
) (
    input  logic        pixel_clk,
    input  logic        rst_n,
    input  logic [10:0] h_coord,
    input  logic [9:0]  v_coord,
    input  logic [7:0]  accel_data_x,
    input  logic [7:0]  accel_data_y,
    input  logic        cnt_clr_i,
    output logic        tick_next_o,
    output logic        frame_tick_o,
    output logic [7:0]  frame_cnt_o,
    output logic [7:0]  accel_x_eof_o,
    output logic [7:0]  accel_y_eof_o
);

    localparam logic [9:0] BLANK_LINE = 10'(V_ACTIVE);

    logic       tick_q;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] ax_q, ay_q;

    assign tick_next_o = (h_coord == 11'd0) && (v_coord == BLANK_LINE);

    // A state change clears the count even if a tick lands in the same cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr_i)
            cnt_d = 8'd0;
        else if (tick_q)
            cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q <= 1'b0;
            cnt_q  <= 8'd0;
            ax_q   <= 8'd0;
            ay_q   <= 8'd0;
        end else begin
            tick_q <= tick_next_o;
            cnt_q  <= cnt_d;
            if (tick_next_o) begin
                ax_q <= accel_data_x;
                ay_q <= accel_data_y;
            end
        end
    end

    assign frame_tick_o  = tick_q;
    assign frame_cnt_o   = cnt_q;
    assign accel_x_eof_o = ax_q;
    assign accel_y_eof_o = ay_q;

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: serve timing, scoring, pause and game-over handling,
// with all outputs registered.
module pong_match_ctrl
    import pong_pkg::*;
#(
    parameter int V_ACTIVE           = 600,
    parameter int WIN_SCORE          = 7,
    parameter int SERVE_DELAY_FRAMES = 60,
    parameter int SCORE_HOLD_FRAMES  = 90
) (
    input  logic        pixel_clk,
    input  logic        rst_n,
    input  logic [10:0] h_coord,
    input  logic [9:0]  v_coord,
    input  logic        button_c,
    input  logic        goal_left_i,
    input  logic        goal_right_i,
    input  logic [7:0]  accel_data_x,
    input  logic [7:0]  accel_data_y,
    output logic        frame_tick_o,
    output logic        update_en_o,
    output logic        serve_o,
    output logic        serve_dir_o,
    output logic [3:0]  score_l_o,
    output logic [3:0]  score_r_o,
    output logic [1:0]  winner_o,
    output logic [1:0]  regime_o,
    output logic [7:0]  accel_x_eof_o,
    output logic [7:0]  accel_y_eof_o
);

    localparam logic [7:0] SERVE_LAST = 8'(SERVE_DELAY_FRAMES - 1);
    localparam logic [7:0] HOLD_LAST  = 8'(SCORE_HOLD_FRAMES - 1);
    localparam logic [3:0] WIN_PTS    = 4'(WIN_SCORE);

    logic [2:0] state_q, state_d;
    logic       btn_q, btn_prev_q, press;
    logic [3:0] score_l_q, score_l_d, score_r_q, score_r_d;
    logic [3:0] score_l_inc, score_r_inc;
    logic [1:0] winner_q, winner_d;
    logic       dir_q, dir_d;
    logic       serve_q, serve_d;
    logic [1:0] regime_q;
    logic       update_q;
    logic       tick, tick_next, cnt_clr;
    logic [7:0] frame_cnt;

    assign press       = btn_q & ~btn_prev_q;
    assign cnt_clr     = (state_d != state_q);
    assign score_l_inc = score_l_q + 4'd1;
    assign score_r_inc = score_r_q + 4'd1;

    pong_frame_timer #(.V_ACTIVE(V_ACTIVE)) u_timer (
        .pixel_clk     (pixel_clk),
        .rst_n         (rst_n),
        .h_coord       (h_coord),
        .v_coord       (v_coord),
        .accel_data_x  (accel_data_x),
        .accel_data_y  (accel_data_y),
        .cnt_clr_i     (cnt_clr),
        .tick_next_o   (tick_next),
        .frame_tick_o  (tick),
        .frame_cnt_o   (frame_cnt),
        .accel_x_eof_o (accel_x_eof_o),
        .accel_y_eof_o (accel_y_eof_o)
    );

    always_comb begin
        state_d   = state_q;
        score_l_d = score_l_q;
        score_r_d = score_r_q;
        winner_d  = winner_q;
        dir_d     = dir_q;
        serve_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                score_l_d = 4'd0;
                score_r_d = 4'd0;
                winner_d  = WIN_NONE;
                dir_d     = 1'b1;
                if (press)
                    state_d = ST_SERVE_WAIT;
            end
            ST_SERVE_WAIT: begin
                if (tick && frame_cnt == SERVE_LAST) begin
                    state_d = ST_PLAY;
                    serve_d = 1'b1;
                end
            end
            ST_PLAY: begin
                // Goals take priority over a coincident press.
                if (goal_left_i && goal_right_i) begin
                    state_d = ST_POINT_HOLD;
                end else if (goal_left_i) begin
                    score_r_d = score_r_inc;
                    dir_d     = 1'b0;
                    if (score_r_inc == WIN_PTS) begin
                        state_d  = ST_GAME_OVER;
                        winner_d = WIN_RIGHT;
                    end else begin
                        state_d = ST_POINT_HOLD;
                    end
                end else if (goal_right_i) begin
                    score_l_d = score_l_inc;
                    dir_d     = 1'b1;
                    if (score_l_inc == WIN_PTS) begin
                        state_d  = ST_GAME_OVER;
                        winner_d = WIN_LEFT;
                    end else begin
                        state_d = ST_POINT_HOLD;
                    end
                end else if (press) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (press)
                    state_d = ST_PLAY;
            end
            ST_POINT_HOLD: begin
                if (tick && frame_cnt == HOLD_LAST)
                    state_d = ST_SERVE_WAIT;
            end
            ST_GAME_OVER: begin
                if (press) begin
                    state_d   = ST_IDLE;
                    score_l_d = 4'd0;
                    score_r_d = 4'd0;
                    winner_d  = WIN_NONE;
                    dir_d     = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Button history resets high so a level held through reset is not a press.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            btn_q      <= 1'b1;
            btn_prev_q <= 1'b1;
            score_l_q  <= 4'd0;
            score_r_q  <= 4'd0;
            winner_q   <= WIN_NONE;
            dir_q      <= 1'b1;
            serve_q    <= 1'b0;
            regime_q   <= REGIME_IDLE;
            update_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            btn_q      <= button_c;
            btn_prev_q <= btn_q;
            score_l_q  <= score_l_d;
            score_r_q  <= score_r_d;
            winner_q   <= winner_d;
            dir_q      <= dir_d;
            serve_q    <= serve_d;
            regime_q   <= regime_of(state_d);
            update_q   <= tick_next && (state_d == ST_PLAY);
        end
    end

    assign frame_tick_o = tick;
    assign update_en_o  = update_q;
    assign serve_o      = serve_q;
    assign serve_dir_o  = dir_q;
    assign score_l_o    = score_l_q;
    assign score_r_o    = score_r_q;
    assign winner_o     = winner_q;
    assign regime_o     = regime_q;

endmodule

// File: doc/pong_match_ctrl.md
PONG_MATCH_CTRL -- requirements
Module: pong_match_ctrl

Interface
REQ-001 SHALL have parameters, one per line:
- V_ACTIVE, 600, first blanking line number
- WIN_SCORE, 7, points needed to win (1..15)
- SERVE_DELAY_FRAMES, 60, frames from entering SERVE_WAIT to serve
- SCORE_HOLD_FRAMES, 90, frames held after a point

REQ-002 SHALL have ports, one per line:
- pixel_clk  in  1  sole clock
- rst_n  in  1  reset, asynchronous, active-low
- h_coord  in  11  pixel column from display controller
- v_coord  in  10  pixel line from display controller
- button_c  in  1  debounced start/pause level
- goal_left_i  in  1  1-cycle pulse: ball left via left edge
- goal_right_i  in  1  1-cycle pulse: ball left via right edge
- accel_data_x  in  8  live accelerometer X
- accel_data_y  in  8  live accelerometer Y
- frame_tick_o  out  1  1-cycle pulse per frame
- update_en_o  out  1  game-object update strobe
- serve_o  out  1  1-cycle ball-launch pulse
- serve_dir_o  out  1  0 = toward left player, 1 = toward right player
- score_l_o  out  4  left score
- score_r_o  out  4  right score
- winner_o  out  2  00 none, 01 left, 10 right
- regime_o  out  2  00 idle, 01 match, 10 paused, 11 game over
- accel_x_eof_o  out  8  accel X sampled at frame tick
- accel_y_eof_o  out  8  accel Y sampled at frame tick

Function
REQ-003 SHALL assert frame_tick_o for exactly one cycle, the cycle after h_coord==0 && v_coord==V_ACTIVE is sampled.
REQ-004 SHALL load accel_x_eof_o/accel_y_eof_o from accel_data_x/y in the same cycle frame_tick_o is high.
REQ-005 SHALL detect a button press as a 0->1 transition of registered button_c; a held level produces one press.
REQ-006 SHALL implement FSM states IDLE, SERVE_WAIT, PLAY, PAUSE, POINT_HOLD, GAME_OVER.
REQ-007 IDLE: scores 0, winner 00, serve_dir_o 1; press -> SERVE_WAIT, frame count cleared.
REQ-008 SERVE_WAIT: count frame ticks; on the tick bringing count to SERVE_DELAY_FRAMES, pulse serve_o the next cycle and enter PLAY.
REQ-009 PLAY: update_en_o equals frame_tick_o; in every other state update_en_o SHALL be 0.
REQ-010 PLAY goal_left_i: score_r +1, serve_dir_o 0; goal_right_i: score_l +1, serve_dir_o 1.
REQ-011 Both goal pulses in one cycle SHALL score nothing, keep serve_dir_o, enter POINT_HOLD.
REQ-012 After a score, reaching WIN_SCORE -> GAME_OVER with winner_o set; otherwise -> POINT_HOLD.
REQ-013 Goal and press in the same PLAY cycle: goal wins, press dropped.
REQ-014 PLAY press -> PAUSE; PAUSE press -> PLAY; goals ignored in PAUSE.
REQ-015 POINT_HOLD: after SCORE_HOLD_FRAMES frame ticks -> SERVE_WAIT, count cleared.
REQ-016 Presses ignored in SERVE_WAIT and POINT_HOLD; goals ignored outside PLAY.
REQ-017 GAME_OVER: scores and winner held; press -> IDLE.
REQ-018 regime_o: IDLE 00; SERVE_WAIT/PLAY/POINT_HOLD 01; PAUSE 10; GAME_OVER 11.
REQ-019 All outputs SHALL be registered; frame counter 8 bits, cleared on every state entry.

Reset
REQ-020 rst_n low SHALL immediately force IDLE and all outputs to 0 except serve_dir_o=1, at any point mid-match.
REQ-021 First press after reset release SHALL require a fresh 0->1 edge.

Structure
REQ-022 State enum, regime encodings and winner encodings SHALL live in shared package pong_pkg.
REQ-023 Frame-tick detection, accel sampling and frame counter SHALL form sub-module pong_frame_timer.

Verification (WIN_SCORE=3, SERVE_DELAY_FRAMES=2, SCORE_HOLD_FRAMES=3)
REQ-024 Reset, press button_c -> regime_o 01; serve_o one cycle after 2nd frame_tick_o; serve_dir_o 1.
REQ-025 PLAY, goal_left_i -> score_r_o 1, serve_dir_o 0, next serve after 3+2 ticks.
REQ-026 Both goals in one cycle -> scores unchanged, POINT_HOLD entered.
REQ-027 Press in PLAY -> regime_o 10, update_en_o 0 on ticks, goals ignored; press -> regime_o 01.
REQ-028 Three goal_right_i -> score_l_o 3, winner_o 01, regime_o 11; press -> scores 0, regime_o 00.
REQ-029 rst_n low mid-PLAY with score 2:1 -> all outputs 0 asynchronously, serve_dir_o 1.
